inlier_tally: RTL and testbench

- Sits directly downstream of check_inlier in the RANSAC datapath.
- Accepts one plane hypothesis (n, d) plus a point count, then consumes that many inlier flags from check_inlier via its ovalid/oacknowledge handshake.
- Tallies the inliers and compares the tally with the best hypothesis so far. Retains the best plane and its count for the RANSAC controller.

---
 rtl/inlier_tally_pkg.sv | 31 +++
 rtl/inlier_tally_if.sv | 46 ++++
 rtl/inlier_tally_best_plane_reg.sv | 43 ++++
 rtl/inlier_tally.sv | 126 ++++++++++++
 tb/tb_inlier_tally.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/inlier_tally_pkg.sv
// Shared types for the inlier tally stage: plane/vector types, counter widths and FSM states.
// Stats build switch: INLIER_TALLY_STATS_EN (adds hypothesis/point counters).
package inlier_tally_pkg;

    localparam int COUNT_WIDTH = 21;
    localparam int STAT_WIDTH  = 32;

    typedef logic [31:0] single_t;

    typedef struct packed {
        single_t x;
        single_t y;
        single_t z;
    } vector3s_s;

    typedef logic [COUNT_WIDTH-1:0] tally_t;
    typedef logic [STAT_WIDTH-1:0]  stat_t;

    typedef struct packed {
        vector3s_s n;
        single_t   d;
    } plane_s;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_COMPARE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/inlier_tally_if.sv
// Hypothesis, inlier-stream and result signals of inlier_tally grouped as one bus.
// Stat outputs exist only when INLIER_TALLY_STATS_EN is defined.
interface inlier_tally_if;
    import inlier_tally_pkg::*;

    logic      clear;
    logic      hvalid;
    logic      hready;
    vector3s_s hn;
    single_t   hd;
    tally_t    hpoints;
    logic      ivalid;
    logic      iready;
    logic      inlier;
    logic      ovalid;
    logic      oacknowledge;
    tally_t    count;
    logic      improved;
    logic      best_valid;
    vector3s_s best_n;
    single_t   best_d;
    tally_t    best_count;
`ifdef INLIER_TALLY_STATS_EN
    stat_t     stat_hypotheses;
    stat_t     stat_points;
`endif

    modport slave (
        input  clear, hvalid, hn, hd, hpoints, ivalid, inlier, oacknowledge,
        output hready, iready, ovalid, count, improved,
               best_valid, best_n, best_d, best_count
`ifdef INLIER_TALLY_STATS_EN
        , output stat_hypotheses, stat_points
`endif
    );

    modport master (
        output clear, hvalid, hn, hd, hpoints, ivalid, inlier, oacknowledge,
        input  hready, iready, ovalid, count, improved,
               best_valid, best_n, best_d, best_count
`ifdef INLIER_TALLY_STATS_EN
        , input stat_hypotheses, stat_points
`endif
    );

endinterface

// File: rtl/inlier_tally_best_plane_reg.sv
// Best-so-far plane register: compares a finished tally against the stored best and
// replaces it on a strict improvement (ties keep the older plane).
module best_plane_reg
    import inlier_tally_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   clear_i,
    input  logic   compare_i,
    input  plane_s cur_i,
    input  tally_t tally_i,
    output logic   replace_o,
    output logic   best_valid_o,
    output plane_s best_o,
    output tally_t best_count_o
);

    logic   best_valid_q;
    plane_s best_q;
    tally_t best_count_q;

    assign replace_o    = !best_valid_q || (tally_i > best_count_q);
    assign best_valid_o = best_valid_q;
    assign best_o       = best_q;
    assign best_count_o = best_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            best_valid_q <= 1'b0;
            best_q       <= '0;
            best_count_q <= '0;
        end else if (clear_i) begin
            best_valid_q <= 1'b0;
            best_q       <= '0;
            best_count_q <= '0;
        end else if (compare_i && replace_o) begin
            best_valid_q <= 1'b1;
            best_q       <= cur_i;
            best_count_q <= tally_i;
        end
    end

endmodule

// File: rtl/inlier_tally.sv
// Tallies inlier flags for one plane hypothesis and keeps the best-scoring plane.
// Optional statistics counters are enabled with INLIER_TALLY_STATS_EN.
module inlier_tally
    import inlier_tally_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    inlier_tally_if.slave  bus
);

    state_e state_q, state_d;
    plane_s cur_q, cur_d;
    tally_t remaining_q, remaining_d;
    tally_t tally_q, tally_d;
    tally_t count_q, count_d;
    logic   improved_q, improved_d;

    logic   idle, clear_best, xfer, compare, replace;
    plane_s best_plane;

    assign idle       = (state_q == ST_IDLE);
    assign clear_best = idle && bus.clear;
    assign compare    = (state_q == ST_COMPARE);
    assign xfer       = bus.ivalid && bus.iready;

    // hready is gated by reset so the whole bus reads zero while reset is held
    assign bus.hready   = reset && idle;
    assign bus.iready   = (state_q == ST_COUNT) && (remaining_q != '0);
    assign bus.ovalid   = (state_q == ST_DONE);
    assign bus.count    = count_q;
    assign bus.improved = improved_q;
    assign bus.best_n   = best_plane.n;
    assign bus.best_d   = best_plane.d;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        remaining_d = remaining_q;
        tally_d     = tally_q;
        count_d     = count_q;
        improved_d  = improved_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.hvalid && !bus.clear) begin
                    cur_d       = '{n: bus.hn, d: bus.hd};
                    remaining_d = bus.hpoints;
                    tally_d     = '0;
                    state_d     = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (remaining_q == '0) begin
                    state_d = ST_COMPARE;
                end else if (xfer) begin
                    tally_d     = tally_q + tally_t'(bus.inlier);
                    remaining_d = remaining_q - 1'b1;
                end
            end
            ST_COMPARE: begin
                count_d    = tally_q;
                improved_d = replace;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (bus.oacknowledge) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            remaining_q <= '0;
            tally_q     <= '0;
            count_q     <= '0;
            improved_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            remaining_q <= remaining_d;
            tally_q     <= tally_d;
            count_q     <= count_d;
            improved_q  <= improved_d;
        end
    end

    best_plane_reg u_best (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (clear_best),
        .compare_i    (compare),
        .cur_i        (cur_q),
        .tally_i      (tally_q),
        .replace_o    (replace),
        .best_valid_o (bus.best_valid),
        .best_o       (best_plane),
        .best_count_o (bus.best_count)
    );

`ifdef INLIER_TALLY_STATS_EN
    stat_t stat_hyp_q, stat_pts_q;

    function automatic stat_t sat_inc(input stat_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign bus.stat_hypotheses = stat_hyp_q;
    assign bus.stat_points     = stat_pts_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_hyp_q <= '0;
            stat_pts_q <= '0;
        end else if (clear_best) begin
            stat_hyp_q <= '0;
            stat_pts_q <= '0;
        end else begin
            if (compare) stat_hyp_q <= sat_inc(stat_hyp_q);
            if (xfer)    stat_pts_q <= sat_inc(stat_pts_q);
        end
    end
`endif

endmodule

// File: tb/tb_inlier_tally.sv
// Directed bench for inlier_tally: a reference best-plane model pushes expected results
// to a scoreboard at hypothesis accept; results are popped when ovalid is seen.
module tb_inlier_tally;
    import inlier_tally_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    inlier_tally_if bus ();

    inlier_tally dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        tally_t count;
        logic   improved;
        logic   bv;
        tally_t bc;
        plane_s bp;
    } exp_t;

    exp_t   sb[$];
    logic   m_bv  = 1'b0;
    tally_t m_bc  = '0;
    plane_s m_bp  = '0;
    int     m_pts = 0;
    int     m_hyp = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bv = 1'b0; m_bc = '0; m_bp = '0; m_pts = 0; m_hyp = 0;
        sb.delete();
    endtask

    task automatic wait_hready();
        int guard = 0;
        while (!bus.hready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("hready_wait", bus.hready, 1'b1);
    endtask

    task automatic run_hyp(input plane_s p, input tally_t pts, input logic [63:0] pat,
                           input int max_gap, input int ack_delay, input logic chk_lat);
        int   acc;
        int   guard;
        int   ones = 0;
        exp_t e;
        logic rep;
        for (int i = 0; i < int'(pts); i++) ones += int'(pat[i]);
        wait_hready();
        bus.hvalid = 1'b1; bus.hn = p.n; bus.hd = p.d; bus.hpoints = pts;
        acc = cyc + 1;
        rep = !m_bv || (tally_t'(ones) > m_bc);
        if (rep) begin m_bv = 1'b1; m_bc = tally_t'(ones); m_bp = p; end
        m_pts += int'(pts); m_hyp++;
        sb.push_back('{count: tally_t'(ones), improved: rep, bv: m_bv, bc: m_bc, bp: m_bp});
        @(negedge clock);
        bus.hvalid = 1'b0;
        check("hready_busy", bus.hready, 1'b0);
        for (int i = 0; i < int'(pts); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                bus.ivalid = 1'b0;
                @(negedge clock);
            end
            bus.ivalid = 1'b1; bus.inlier = pat[i];
            guard = 0;
            while (!bus.iready && guard < 100) begin
                @(negedge clock);
                guard++;
            end
            if (guard >= 100) check("iready_timeout", bus.iready, 1'b1);
            @(negedge clock);
        end
        bus.ivalid = 1'b0; bus.inlier = 1'b0;
        guard = 0;
        while (!bus.ovalid && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("ovalid_seen", bus.ovalid, 1'b1);
        if (chk_lat) check("latency", 128'(cyc - acc), 128'(int'(pts) + 2));
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            check("count", bus.count, e.count);
            check("improved", bus.improved, e.improved);
            check("best_valid", bus.best_valid, e.bv);
            check("best_count", bus.best_count, e.bc);
            check("best_n", bus.best_n, e.bp.n);
            check("best_d", bus.best_d, e.bp.d);
            repeat (ack_delay) begin
                @(negedge clock);
                check("ovalid_hold", bus.ovalid, 1'b1);
                check("count_hold", bus.count, e.count);
                check("improved_hold", bus.improved, e.improved);
                check("hready_hold", bus.hready, 1'b0);
            end
        end
        bus.oacknowledge = 1'b1;
        @(negedge clock);
        bus.oacknowledge = 1'b0;
        check("ovalid_after_ack", bus.ovalid, 1'b0);
        check("hready_after_ack", bus.hready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        plane_s pa, pb, pc, pz, pd, pe;
        pa = '{n: '{x: 32'h3F80_0000, y: 32'h0, z: 32'h0}, d: 32'h4000_0000};
        pb = '{n: '{x: 32'h0, y: 32'h3F80_0000, z: 32'h0}, d: 32'hC000_0000};
        pc = '{n: '{x: 32'h0, y: 32'h0, z: 32'h3F80_0000}, d: 32'h4040_0000};
        pz = '{n: '{x: 32'h1111_1111, y: 32'h2222_2222, z: 32'h3333_3333}, d: 32'h4444_4444};
        pd = '{n: '{x: 32'hBF80_0000, y: 32'h3F00_0000, z: 32'h3E80_0000}, d: 32'h1234_5678};
        pe = '{n: '{x: 32'hAAAA_5555, y: 32'h5555_AAAA, z: 32'h0F0F_F0F0}, d: 32'hDEAD_BEEF};

        bus.clear = 1'b0; bus.hvalid = 1'b0; bus.hn = '0; bus.hd = '0; bus.hpoints = '0;
        bus.ivalid = 1'b0; bus.inlier = 1'b0; bus.oacknowledge = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_hready", bus.hready, 1'b0);
        check("rst_iready", bus.iready, 1'b0);
        check("rst_ovalid", bus.ovalid, 1'b0);
        check("rst_count", bus.count, '0);
        check("rst_improved", bus.improved, 1'b0);
        check("rst_best_valid", bus.best_valid, 1'b0);
        check("rst_best_count", bus.best_count, '0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rel_hready", bus.hready, 1'b1);
        check("rel_iready", bus.iready, 1'b0);

        // hpoints=0 with no best yet: two cycles to ovalid, count 0, improved
        run_hyp(pz, '0, 64'h0, 0, 0, 1'b1);
        // A: pattern 1,0,1,1,0,0,1,0 -> 4 inliers
        run_hyp(pa, 21'd8, 64'h4D, 0, 0, 1'b1);
        // B: 4 inliers ties, best stays A
        run_hyp(pb, 21'd8, 64'h0F, 0, 1, 1'b0);
        // C: 5 inliers replaces
        run_hyp(pc, 21'd8, 64'h1F, 0, 0, 1'b1);
        // D: random ivalid gaps, result held 10 cycles without ack
        run_hyp(pd, 21'd12, {32'h0, $urandom()}, 3, 10, 1'b0);
`ifdef INLIER_TALLY_STATS_EN
        check("stat_hyp", bus.stat_hypotheses, m_hyp);
        check("stat_pts", bus.stat_points, m_pts);
`endif

        // clear concurrent with hvalid: hypothesis rejected, best wiped
        wait_hready();
        bus.clear = 1'b1; bus.hvalid = 1'b1; bus.hn = pe.n; bus.hd = pe.d; bus.hpoints = 21'd3;
        @(negedge clock);
        bus.clear = 1'b0; bus.hvalid = 1'b0;
        m_bv = 1'b0; m_bc = '0; m_bp = '0; m_pts = 0; m_hyp = 0;
        check("clear_rejects", bus.hready, 1'b1);
        check("clear_iready", bus.iready, 1'b0);
        check("clear_best_valid", bus.best_valid, 1'b0);
        check("clear_best_count", bus.best_count, '0);
        check("clear_best_n", bus.best_n, '0);
`ifdef INLIER_TALLY_STATS_EN
        check("clear_stat_hyp", bus.stat_hypotheses, '0);
        check("clear_stat_pts", bus.stat_points, '0);
`endif
        run_hyp(pe, 21'd3, 64'h0, 1, 0, 1'b0);

        // reset in the middle of a hypothesis with three points remaining
        wait_hready();
        bus.hvalid = 1'b1; bus.hn = pa.n; bus.hd = pa.d; bus.hpoints = 21'd5;
        @(negedge clock);
        bus.hvalid = 1'b0;
        bus.ivalid = 1'b1; bus.inlier = 1'b1;
        repeat (2) @(negedge clock);
        bus.ivalid = 1'b0;
        check("mid_iready", bus.iready, 1'b1);
`ifdef INLIER_TALLY_STATS_EN
        check("mid_stat_pts", bus.stat_points, m_pts + 2);
`endif
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_hready", bus.hready, 1'b0);
        check("async_iready", bus.iready, 1'b0);
        check("async_ovalid", bus.ovalid, 1'b0);
        check("async_count", bus.count, '0);
        check("async_improved", bus.improved, 1'b0);
        check("async_best_valid", bus.best_valid, 1'b0);
        check("async_best_count", bus.best_count, '0);
        check("async_best_n", bus.best_n, '0);
        check("async_best_d", bus.best_d, '0);
`ifdef INLIER_TALLY_STATS_EN
        check("async_stat_hyp", bus.stat_hypotheses, '0);
        check("async_stat_pts", bus.stat_points, '0);
`endif
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_hready", bus.hready, 1'b1);
        check("post_best_valid", bus.best_valid, 1'b0);

        // fresh start after reset: first hypothesis always improves
        run_hyp(pb, 21'd4, 64'h2, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
